fir_mac_seq: RTL and testbench

//  Parametrised, time-multiplexed FIR filter that supersedes the fixed 6-bit-in / 8-bit-out FIR core.
//  One shared signed multiplier-accumulator computes TAPS products per sample, sequenced by a small FSM.

---
 rtl/fir_mac_seq.sv | 165 ++++++++++++++++
 tb/tb_fir_mac_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR filter: one shared signed MAC evaluates TAPS products per sample.
// Output is rounded (half up), then saturated. Coefficients can be reloaded at runtime while idle.
module fir_mac_seq #(
  parameter int DATA_W = 6,
  parameter int COEF_W = 6,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              coef_load,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              busy
);

  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PTR_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RND_W  = ACC_W + 1;
  localparam int SAT_W  = (RND_W > OUT_W) ? RND_W : OUT_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TAPS - 1);
  localparam logic signed [SAT_W-1:0] SAT_MAX = SAT_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;

  // busy mirrors the one-bit state register, so it doubles as the FSM debug view.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_MAC  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic signed [DATA_W-1:0] r_x [TAPS];
  logic signed [COEF_W-1:0] r_c [TAPS];
  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_idx;
  logic signed [ACC_W-1:0]  r_acc;
  logic [OUT_W-1:0]         r_out_data;
  logic                     r_out_valid;

  logic                     w_ready;
  logic                     w_busy;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_coef_wr;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [RND_W-1:0]  w_rnd;
  logic signed [SAT_W-1:0]  w_wide;
  logic [OUT_W-1:0]         w_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid && !coef_load) w_next_state = S_MAC;
      S_MAC:   if (r_idx == LAST_IDX) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Input handshake: a sample transfers on a rising edge where in_valid && in_ready.
  // in_ready is high only in IDLE with coef_load low, so a coefficient write always wins.
  always_comb begin
    w_ready   = 1'b0;
    w_busy    = 1'b0;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    w_coef_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready   = !coef_load;
        w_accept  = in_valid && !coef_load;
        w_coef_wr = coef_load && coef_valid;
      end
      S_MAC: begin
        w_busy = 1'b1;
        w_last = (r_idx == LAST_IDX);
      end
      default: ;
    endcase
  end

  assign w_prod = r_x[r_idx] * r_c[r_idx];
  assign w_sum  = r_acc + $signed({{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod});

  // One guard bit keeps the rounding offset from wrapping the accumulator.
  if (SHIFT > 0) begin : g_round
    localparam logic signed [RND_W-1:0] HALF = RND_W'(2 ** (SHIFT - 1));
    assign w_rnd = ($signed({w_sum[ACC_W-1], w_sum}) + HALF) >>> SHIFT;
  end else begin : g_no_round
    assign w_rnd = $signed({w_sum[ACC_W-1], w_sum});
  end

  assign w_wide = SAT_W'(w_rnd);

  always_comb begin
    w_sat = w_wide[OUT_W-1:0];
    if (w_wide > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_wide < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      for (int k = TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
      r_x[0] <= in_data;
      r_acc  <= '0;
      r_idx  <= '0;
    end else if (w_busy) begin
      r_acc <= w_sum;
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // The pointer only moves while idle; it rewinds whenever coef_load is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) r_c[k] <= '0;
      r_wptr <= '0;
    end else if (w_coef_wr) begin
      r_c[r_wptr] <= coef_data;
      r_wptr      <= (r_wptr == LAST_IDX) ? '0 : r_wptr + 1'b1;
    end else if ((r_state == S_IDLE) && !coef_load) begin
      r_wptr <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_last;
      if (w_last) r_out_data <= w_sat;
    end
  end

  assign in_ready  = w_ready;
  assign busy      = w_busy;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed and randomized bench for fir_mac_seq; expected outputs come from an
// arithmetic FIR model (integer dot product, round half up, clamp).
module tb_fir_mac_seq;
  localparam int DATA_W = 6;
  localparam int COEF_W = 6;
  localparam int TAPS   = 8;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              coef_load;
  logic [COEF_W-1:0] coef_data;
  logic              coef_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              busy;

  always #5 clk = ~clk;

  fir_mac_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_load(coef_load), .coef_data(coef_data), .coef_valid(coef_valid),
    .out_data(out_data), .out_valid(out_valid), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_x[TAPS];
  int m_c[TAPS];
  int m_wptr;
  logic [OUT_W-1:0] exp_q[$];
  int q_coef[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int model_out();
    int s;
    int r;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += m_x[k] * m_c[k];
    r = s;
    if (SHIFT > 0) r = (s + (1 <<< (SHIFT - 1))) >>> SHIFT;
    if (r > (2 ** (OUT_W - 1)) - 1) r = (2 ** (OUT_W - 1)) - 1;
    if (r < -(2 ** (OUT_W - 1))) r = -(2 ** (OUT_W - 1));
    return r;
  endfunction

  task automatic model_shift(input int x);
    for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = x;
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      m_x[k] = 0;
      m_c[k] = 0;
    end
    m_wptr = 0;
    exp_q.delete();
  endtask

  function automatic int rnd_s(input int w);
    return int'($urandom_range(0, (2 ** w) - 1)) - (2 ** (w - 1));
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    coef_load = 1'b0;
    coef_valid = 1'b0;
    coef_data = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    model_clear();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
  endtask

  // Writes q_coef as one coef_load burst; optionally holds in_valid to check that loading wins.
  task automatic load_coefs(input bit with_valid);
    coef_load = 1'b1;
    in_valid = with_valid;
    in_data = DATA_W'(rnd_s(DATA_W));
    foreach (q_coef[i]) begin
      coef_valid = 1'b1;
      coef_data = COEF_W'(q_coef[i]);
      #1;
      if (with_valid) chk("load_ready_low", in_ready, 0);
      tick();
      m_c[m_wptr] = q_coef[i];
      m_wptr = (m_wptr == TAPS - 1) ? 0 : m_wptr + 1;
    end
    coef_valid = 1'b0;
    coef_load = 1'b0;
    in_valid = 1'b0;
    tick();
    m_wptr = 0;
  endtask

  task automatic rand_coefs(input int n);
    q_coef.delete();
    for (int i = 0; i < n; i++) q_coef.push_back(rnd_s(COEF_W));
  endtask

  task automatic send_sample(input int x, output logic [OUT_W-1:0] got);
    int wait_n;
    int lat;
    wait_n = 0;
    lat = 0;
    in_data = DATA_W'(x);
    in_valid = 1'b1;
    #1;
    while (!in_ready && wait_n < 50) begin
      tick();
      #1;
      wait_n++;
    end
    chk("accept_in_time", (wait_n < 50), 1);
    tick();
    in_valid = 1'b0;
    model_shift(x);
    exp_q.push_back(OUT_W'(model_out()));
    chk("mac_busy", busy, 1);
    chk("mac_ready_low", in_ready, 0);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, TAPS);
    got = out_data;
    chk("out_model", out_data, exp_q.pop_front());
    tick();
    chk("pulse_one_cycle", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] got;
    int exp3[7];
    int exp6[8];
    int accepts;
    int last;
    int cyc;
    int cur_x;
    int pulses;
    int d;
    bit took;

    rst_n = 1'b1;
    #1;
    reset_dut();

    // Zero coefficients give a zero result after TAPS cycles.
    send_sample(5, got);
    chk("t1_zero", got, 0);

    // Single tap of 16 passes the sample through; load overlaps a pending sample.
    q_coef = '{16, 0, 0, 0, 0, 0, 0, 0};
    load_coefs(1'b1);
    send_sample(5, got);
    chk("t2_pos", got, 8'h05);
    send_sample(-3, got);
    chk("t2_neg", got, 8'hFD);
    q_coef = '{8};
    load_coefs(1'b0);
    send_sample(1, got);
    chk("t2_round_up", got, 8'h01);
    send_sample(-1, got);
    chk("t2_round_half", got, 8'h00);

    // Positive and negative saturation.
    reset_dut();
    q_coef = '{16, 16, 16, 16, 16, 16, 16, 16};
    load_coefs(1'b0);
    exp3 = '{31, 62, 93, 124, 127, 127, 127};
    for (int i = 0; i < 7; i++) begin
      send_sample(31, got);
      chk("t3_pos_sat", got, OUT_W'(exp3[i]));
    end
    reset_dut();
    q_coef = '{31, 31, 31, 31, 31, 31, 31, 31};
    load_coefs(1'b0);
    send_sample(-32, got);
    chk("t3_neg_a", got, 8'hC2);
    send_sample(-32, got);
    chk("t3_neg_b", got, 8'h84);
    send_sample(-32, got);
    chk("t3_neg_sat", got, 8'h80);

    // Back-to-back samples with coef_load noise during MAC.
    reset_dut();
    rand_coefs(TAPS);
    load_coefs(1'b0);
    accepts = 0;
    last = -1;
    cyc = 0;
    took = 1'b0;
    cur_x = rnd_s(DATA_W);
    in_data = DATA_W'(cur_x);
    in_valid = 1'b1;
    while (accepts < 6 && cyc < 200) begin
      if (took) begin
        cur_x = rnd_s(DATA_W);
        in_data = DATA_W'(cur_x);
        took = 1'b0;
      end
      coef_load = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      coef_valid = 1'($urandom_range(0, 1));
      coef_data = COEF_W'($urandom);
      #1;
      if (out_valid) chk("t4_out", out_data, exp_q.pop_front());
      if (in_ready) begin
        model_shift(cur_x);
        exp_q.push_back(OUT_W'(model_out()));
        if (last >= 0) chk("t4_gap", cyc - last, TAPS + 1);
        last = cyc;
        accepts++;
        took = 1'b1;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    coef_load = 1'b0;
    coef_valid = 1'b0;
    d = 0;
    while (!out_valid && d < 20) begin
      tick();
      d++;
    end
    chk("t4_drain", out_data, exp_q.pop_front());
    chk("t4_accepts", accepts, 6);
    chk("t4_queue_empty", exp_q.size(), 0);
    send_sample(rnd_s(DATA_W), got);

    // Reset in the middle of a MAC sequence.
    rand_coefs(TAPS);
    q_coef[0] = 17;
    load_coefs(1'b0);
    in_data = DATA_W'(7);
    in_valid = 1'b1;
    #1;
    chk("t5_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t5_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", busy, 0);
    chk("t5_valid_rst", out_valid, 0);
    tick();
    rst_n = 1'b1;
    model_clear();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("t5_no_pulse", pulses, 0);
    chk("t5_out_zero", out_data, 0);
    chk("t5_ready_after", in_ready, 1);
    send_sample(rnd_s(DATA_W), got);
    chk("t5_coefs_cleared", got, 0);

    // Pointer wrap on a 9-write burst, then rewind after coef_load drops.
    reset_dut();
    q_coef = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    load_coefs(1'b0);
    q_coef = '{5};
    load_coefs(1'b0);
    exp6 = '{5, 2, 3, 4, 5, 6, 7, 8};
    for (int i = 0; i < TAPS; i++) begin
      send_sample((i == 0) ? 16 : 0, got);
      chk("t6_coef", got, OUT_W'(exp6[i]));
    end

    // Random coefficients, samples and partial reloads.
    reset_dut();
    for (int r = 0; r < 4; r++) begin
      rand_coefs(int'($urandom_range(1, 12)));
      load_coefs(1'($urandom_range(0, 1)));
      for (int i = 0; i < 6; i++) send_sample(rnd_s(DATA_W), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
